// File: rtl/ball_engine.sv
// Rectangular bouncing ball with neighbour-ring collision sensing and serve/run/miss control.
// Define HIT_COUNT_EN to build the saturating bounce counter on hit_count.
module ball_engine #(
    parameter int XSIZE      = 5,
    parameter int YSIZE      = 5,
    parameter int MAXSTEP    = 4,
    parameter bit XDIR_START = 1'b0,
    parameter bit YDIR_START = 1'b0,
    parameter int YMISS      = 479
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixpulse,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic [9:0]  xloc_start,
    input  logic [9:0]  yloc_start,
    input  logic        empty,
    input  logic        move,
    input  logic        serve,
    input  logic [2:0]  xstep,
    input  logic [2:0]  ystep,
    output logic        draw_ball,
    output logic [9:0]  xloc,
    output logic [9:0]  yloc,
    output logic        xdir,
    output logic        ydir,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic        miss,
    output logic        running,
    output logic [15:0] hit_count
);

    localparam int HX = (XSIZE - 1) / 2;
    localparam int HY = (YSIZE - 1) / 2;
    localparam int CW = YSIZE + 2;
    localparam int RW = XSIZE + 2;

    localparam logic [9:0]  HXV    = 10'(HX);
    localparam logic [9:0]  HYV    = 10'(HY);
    localparam logic [9:0]  HX1    = 10'(HX + 1);
    localparam logic [9:0]  HY1    = 10'(HY + 1);
    localparam logic [9:0]  XSPAN  = 10'(XSIZE - 1);
    localparam logic [9:0]  YSPAN  = 10'(YSIZE - 1);
    localparam logic [9:0]  XRING  = 10'(XSIZE + 1);
    localparam logic [9:0]  YRING  = 10'(YSIZE + 1);
    localparam logic [10:0] YMISSV = 11'(YMISS);
    localparam logic [10:0] HY11   = 11'(HY);
    localparam logic [2:0]  MAXS   = 3'(MAXSTEP);

    localparam logic [CW-1:0] COL_BOT = CW'(1);
    localparam logic [CW-1:0] COL_TOP = COL_BOT << (CW - 1);
    localparam logic [RW-1:0] ROW_RGT = RW'(1);
    localparam logic [RW-1:0] ROW_LFT = ROW_RGT << (RW - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state;
    logic          clr_pend;
    logic [CW-1:0] lft, rgt, lft_nx, rgt_nx;
    logic [RW-1:0] top, bot, top_nx, bot_nx;

    logic [9:0] dxd, dyd, rv, rh;
    logic       on_lft, on_rgt, on_top, on_bot;

    logic [9:0] sx, sy, x_new, y_new;
    logic       x_hit, y_hit, x_wall, y_wall, x_dn, y_dn;
    logic       miss_now, serve_go, move_go;

    function automatic logic [9:0] clamp_step(input logic [2:0] st);
        logic [2:0] s;
        if (st == 3'd0)
            s = 3'd1;
        else if (st > MAXS)
            s = MAXS;
        else
            s = st;
        return {7'd0, s};
    endfunction

    // Ball footprint test against the current raster position
    always_comb begin
        dxd       = hcount - xloc + HXV;
        dyd       = vcount - yloc + HYV;
        draw_ball = (dxd <= XSPAN) && (dyd <= YSPAN);
    end

    // Map a non-empty raster pixel onto the four neighbour rings
    always_comb begin
        rv     = yloc + HY1 - vcount;
        rh     = xloc + HX1 - hcount;
        on_lft = ~empty && (hcount == xloc - HX1) && (rv <= YRING);
        on_rgt = ~empty && (hcount == xloc + HX1) && (rv <= YRING);
        on_top = ~empty && (vcount == yloc - HY1) && (rh <= XRING);
        on_bot = ~empty && (vcount == yloc + HY1) && (rh <= XRING);
        lft_nx = lft | (on_lft ? (COL_BOT << rv) : '0);
        rgt_nx = rgt | (on_rgt ? (COL_BOT << rv) : '0);
        top_nx = top | (on_top ? (ROW_RGT << rh) : '0);
        bot_nx = bot | (on_bot ? (ROW_RGT << rh) : '0);
    end

    // Per-axis blocking, edge walls and the candidate next position
    always_comb begin
        sx       = clamp_step(xstep);
        sy       = clamp_step(ystep);
        x_hit    = |((xdir ? rgt : lft) & ~(ydir ? COL_TOP : COL_BOT));
        y_hit    = |((ydir ? bot : top) & ~(xdir ? ROW_LFT : ROW_RGT));
        x_wall   = x_hit || (!xdir && (xloc < HXV + sx));
        y_wall   = y_hit || (!ydir && (yloc < HYV + sy));
        x_dn     = xdir ^ x_wall;
        y_dn     = ydir ^ y_wall;
        x_new    = x_dn ? xloc + sx : xloc - sx;
        y_new    = y_dn ? yloc + sy : yloc - sy;
        miss_now = ({1'b0, y_new} + HY11) >= YMISSV;
        serve_go = pixpulse && (state == S_IDLE) && serve;
        move_go  = pixpulse && (state == S_RUN) && move;
    end

    // Serve/run/miss control, motion and ring accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            xloc     <= xloc_start;
            yloc     <= yloc_start;
            xdir     <= XDIR_START;
            ydir     <= YDIR_START;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            miss     <= 1'b0;
            clr_pend <= 1'b0;
            lft      <= '0;
            rgt      <= '0;
            top      <= '0;
            bot      <= '0;
        end else if (pixpulse) begin
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            miss     <= 1'b0;
            clr_pend <= 1'b0;
            if (clr_pend) begin
                lft <= '0;
                rgt <= '0;
                top <= '0;
                bot <= '0;
            end else begin
                lft <= lft_nx;
                rgt <= rgt_nx;
                top <= top_nx;
                bot <= bot_nx;
            end
            case (state)
                S_IDLE: begin
                    xloc <= xloc_start;
                    yloc <= yloc_start;
                    if (serve_go) begin
                        state <= S_RUN;
                        xdir  <= XDIR_START;
                        ydir  <= YDIR_START;
                        lft   <= '0;
                        rgt   <= '0;
                        top   <= '0;
                        bot   <= '0;
                    end
                end
                default: begin
                    if (move_go) begin
                        xloc     <= x_new;
                        yloc     <= y_new;
                        xdir     <= x_dn;
                        ydir     <= y_dn;
                        bounce_x <= x_wall;
                        bounce_y <= y_wall;
                        clr_pend <= 1'b1;
                        if (miss_now) begin
                            state <= S_IDLE;
                            miss  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign running = (state == S_RUN);

`ifdef HIT_COUNT_EN
    // Count moves that reversed at least one axis, saturating
    always_ff @(posedge clk) begin
        if (rst || serve_go)
            hit_count <= '0;
        else if (move_go && (x_wall || y_wall) && (hit_count != 16'hFFFF))
            hit_count <= hit_count + 16'd1;
    end
`else
    assign hit_count = 16'd0;
`endif

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: directed literal checks plus
// randomized raster/obstacle stimulus against a behavioural model.
module tb_ball_engine;

    localparam int XSIZE      = 5;
    localparam int YSIZE      = 5;
    localparam int MAXSTEP    = 4;
    localparam bit XDIR_START = 1'b0;
    localparam bit YDIR_START = 1'b0;
    localparam int YMISS      = 479;
    localparam int HX         = (XSIZE - 1) / 2;
    localparam int HY         = (YSIZE - 1) / 2;

    logic        clk = 1'b0;
    logic        rst, pixpulse, empty, move, serve;
    logic [9:0]  hcount, vcount, xloc_start, yloc_start;
    logic [2:0]  xstep, ystep;
    logic        draw_ball, xdir, ydir, bounce_x, bounce_y, miss, running;
    logic [9:0]  xloc, yloc;
    logic [15:0] hit_count;

    always #5 clk = ~clk;

    ball_engine #(
        .XSIZE(XSIZE), .YSIZE(YSIZE), .MAXSTEP(MAXSTEP),
        .XDIR_START(XDIR_START), .YDIR_START(YDIR_START), .YMISS(YMISS)
    ) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse),
        .hcount(hcount), .vcount(vcount),
        .xloc_start(xloc_start), .yloc_start(yloc_start),
        .empty(empty), .move(move), .serve(serve),
        .xstep(xstep), .ystep(ystep),
        .draw_ball(draw_ball), .xloc(xloc), .yloc(yloc),
        .xdir(xdir), .ydir(ydir),
        .bounce_x(bounce_x), .bounce_y(bounce_y),
        .miss(miss), .running(running), .hit_count(hit_count)
    );

    int checks = 0;
    int errors = 0;
    bit model_ok = 1'b0;

    // Obstacle pixels seen this frame, with the ball centre at sampling time
    typedef struct {
        int h;
        int v;
        int xl;
        int yl;
    } samp_t;
    samp_t smp[$];

    int m_x, m_y, m_hits;
    bit m_xd, m_yd, m_run, m_bx, m_by, m_miss, m_clr;

    function automatic int sd(int a, int b);
        return ((a - b + 512) & 1023) - 512;
    endfunction

    function automatic int iabs(int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int step_of(int st);
        if (st == 0) return 1;
        if (st > MAXSTEP) return MAXSTEP;
        return st;
    endfunction

    function automatic bit m_draw();
        return iabs(sd(int'(hcount), m_x)) <= HX &&
               iabs(sd(int'(vcount), m_y)) <= HY;
    endfunction

    function automatic void model_step();
        int sx, sy, ex, ey, nx, ny;
        bit xb, yb, xw, yw, clr_now, on;
        samp_t rec;
        if (rst) begin
            m_x = int'(xloc_start);
            m_y = int'(yloc_start);
            m_xd = XDIR_START;
            m_yd = YDIR_START;
            m_run = 0; m_bx = 0; m_by = 0; m_miss = 0; m_clr = 0;
            m_hits = 0;
            smp.delete();
            model_ok = 1'b1;
            return;
        end
        if (!pixpulse) return;
        m_bx = 0; m_by = 0; m_miss = 0;
        clr_now = m_clr;
        m_clr = 0;
        rec.h = int'(hcount);
        rec.v = int'(vcount);
        rec.xl = m_x;
        rec.yl = m_y;
        ex = sd(rec.h, m_x);
        ey = sd(rec.v, m_y);
        on = !empty &&
             ((iabs(ex) == HX + 1 && iabs(ey) <= HY + 1) ||
              (iabs(ey) == HY + 1 && iabs(ex) <= HX + 1));
        if (!m_run) begin
            if (serve) begin
                m_run = 1;
                m_xd = XDIR_START;
                m_yd = YDIR_START;
                smp.delete();
                m_hits = 0;
            end else if (clr_now) begin
                smp.delete();
            end else if (on) begin
                smp.push_back(rec);
            end
            m_x = int'(xloc_start);
            m_y = int'(yloc_start);
            return;
        end
        xb = 0; yb = 0; xw = 0; yw = 0;
        nx = m_x; ny = m_y;
        if (move) begin
            sx = step_of(int'(xstep));
            sy = step_of(int'(ystep));
            foreach (smp[i]) begin
                ex = sd(smp[i].h, smp[i].xl);
                ey = sd(smp[i].v, smp[i].yl);
                if (ex == (m_xd ? HX + 1 : -(HX + 1)) && iabs(ey) <= HY + 1 &&
                    ey != (m_yd ? -(HY + 1) : HY + 1))
                    xb = 1;
                if (ey == (m_yd ? HY + 1 : -(HY + 1)) && iabs(ex) <= HX + 1 &&
                    ex != (m_xd ? -(HX + 1) : HX + 1))
                    yb = 1;
            end
            xw = xb || (!m_xd && m_x < HX + sx);
            yw = yb || (!m_yd && m_y < HY + sy);
            if (xw) m_xd = !m_xd;
            if (yw) m_yd = !m_yd;
            nx = (m_xd ? m_x + sx : m_x - sx) & 1023;
            ny = (m_yd ? m_y + sy : m_y - sy) & 1023;
        end
        if (clr_now) smp.delete();
        else if (on) smp.push_back(rec);
        if (move) begin
            m_x = nx;
            m_y = ny;
            m_bx = xw;
            m_by = yw;
            m_clr = 1;
`ifdef HIT_COUNT_EN
            if ((xw || yw) && m_hits < 65535) m_hits++;
`endif
            if (ny + HY >= YMISS) begin
                m_run = 0;
                m_miss = 1;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic px();
        pixpulse = 1'b0;
        tick(); tick(); tick();
        pixpulse = 1'b1;
        tick();
        pixpulse = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pixpulse = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Cycle-by-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                checks++;
                if (draw_ball !== m_draw() || xloc !== 10'(m_x) ||
                    yloc !== 10'(m_y) || xdir !== m_xd || ydir !== m_yd ||
                    bounce_x !== m_bx || bounce_y !== m_by ||
                    miss !== m_miss || running !== m_run ||
                    hit_count !== 16'(m_hits)) begin
                    errors++;
                    $display("FAIL compare t=%0t got d=%b x=%0d y=%0d xd=%b yd=%b bx=%b by=%b m=%b r=%b h=%0d expected d=%b x=%0d y=%0d xd=%b yd=%b bx=%b by=%b m=%b r=%b h=%0d",
                             $time, draw_ball, xloc, yloc, xdir, ydir, bounce_x,
                             bounce_y, miss, running, hit_count, m_draw(), m_x,
                             m_y, m_xd, m_yd, m_bx, m_by, m_miss, m_run, m_hits);
                end
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_hits;
        rst = 1'b1; pixpulse = 1'b0; hcount = '0; vcount = '0;
        xloc_start = 10'd320; yloc_start = 10'd240;
        empty = 1'b1; move = 1'b0; serve = 1'b0;
        xstep = 3'd1; ystep = 3'd1;
        tick();
        rst = 1'b0;
        chk("reset xloc", int'(xloc), 320);
        chk("reset yloc", int'(yloc), 240);
        chk("reset running", int'(running), 0);

        move = 1'b1;
        repeat (10) px();
        move = 1'b0;
        chk("idle xloc", int'(xloc), 320);
        chk("idle yloc", int'(yloc), 240);
        chk("idle running", int'(running), 0);

        serve = 1'b1; px(); serve = 1'b0;
        chk("serve running", int'(running), 1);
        move = 1'b1; px();
        chk("step1 xloc", int'(xloc), 319);
        chk("step1 yloc", int'(yloc), 239);
        xstep = 3'd0; px();
        chk("xstep0 xloc", int'(xloc), 318);
        xstep = 3'd7; px();
        move = 1'b0;
        chk("xstep7 xloc", int'(xloc), 314);
        chk("xstep7 yloc", int'(yloc), 237);
        px();

        empty = 1'b0; hcount = 10'd311;
        for (int v = 235; v <= 239; v++) begin
            vcount = 10'(v);
            px();
        end
        empty = 1'b1; hcount = '0; vcount = '0;
        xstep = 3'd1; ystep = 3'd1;
        move = 1'b1; px(); move = 1'b0;
        chk("column xdir", int'(xdir), 1);
        chk("column xloc", int'(xloc), 315);
        chk("column bounce_x", int'(bounce_x), 1);
        chk("column bounce_y", int'(bounce_y), 0);
        chk("column ydir", int'(ydir), 0);
        chk("column yloc", int'(yloc), 236);

        do_reset();
        serve = 1'b1; px(); serve = 1'b0;
        move = 1'b1; px(); move = 1'b0;
        px();
        empty = 1'b0; hcount = 10'd316; vcount = 10'd236; px();
        empty = 1'b1; hcount = '0; vcount = '0;
        move = 1'b1; px(); move = 1'b0;
        chk("corner xdir", int'(xdir), 1);
        chk("corner ydir", int'(ydir), 1);
        chk("corner xloc", int'(xloc), 320);
        chk("corner yloc", int'(yloc), 240);
        chk("corner bounce_x", int'(bounce_x), 1);
        chk("corner bounce_y", int'(bounce_y), 1);
`ifdef HIT_COUNT_EN
        exp_hits = 1;
`else
        exp_hits = 0;
`endif
        chk("corner hit_count", int'(hit_count), exp_hits);

        yloc_start = 10'd471;
        do_reset();
        serve = 1'b1; px(); serve = 1'b0;
        empty = 1'b0; hcount = 10'd320; vcount = 10'd468; px();
        empty = 1'b1; hcount = '0; vcount = '0;
        ystep = 3'd3; move = 1'b1; px(); move = 1'b0;
        chk("topwall ydir", int'(ydir), 1);
        chk("topwall yloc", int'(yloc), 474);
        chk("topwall miss", int'(miss), 0);
        px();
        ystep = 3'd4; move = 1'b1; px(); move = 1'b0;
        chk("miss pulse", int'(miss), 1);
        chk("miss running", int'(running), 0);
        chk("miss yloc", int'(yloc), 478);
        px();
        chk("miss clear", int'(miss), 0);
        chk("reload xloc", int'(xloc), 320);
        chk("reload yloc", int'(yloc), 471);

        serve = 1'b1; px(); serve = 1'b0;
        chk("reserve running", int'(running), 1);
        xloc_start = 10'd100; yloc_start = 10'd100;
        move = 1'b1; pixpulse = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; pixpulse = 1'b0; move = 1'b0;
        chk("rst-move xloc", int'(xloc), 100);
        chk("rst-move yloc", int'(yloc), 100);
        chk("rst-move running", int'(running), 0);

        xloc_start = 10'd4; yloc_start = 10'd240;
        do_reset();
        serve = 1'b1; px(); serve = 1'b0;
        xstep = 3'd3; ystep = 3'd1;
        move = 1'b1; px(); move = 1'b0;
        chk("edge xdir", int'(xdir), 1);
        chk("edge xloc", int'(xloc), 7);
        chk("edge bounce_x", int'(bounce_x), 1);

        for (int r = 0; r < 6; r++) begin
            xloc_start = 10'($urandom_range(150, 650));
            yloc_start = 10'($urandom_range(100, 350));
            do_reset();
            for (int k = 0; k < 600; k++) begin
                hcount = 10'(m_x + int'($urandom_range(0, 10)) - 5);
                vcount = 10'(m_y + int'($urandom_range(0, 10)) - 5);
                empty  = ($urandom_range(0, 5) != 0);
                move   = ($urandom_range(0, 3) == 0);
                serve  = ($urandom_range(0, 7) == 0);
                xstep  = 3'($urandom_range(0, 7));
                ystep  = 3'($urandom_range(0, 7));
                rst    = ($urandom_range(0, 299) == 0);
                px();
                rst = 1'b0;
            end
            move = 1'b0;
            serve = 1'b0;
            empty = 1'b1;
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Parametrised successor to the fixed-size bouncing-ball sprite: rectangular ball of XSIZE x YSIZE pixels with programmable per-axis step (1..MAXSTEP pixels per move), collision sensing against non-empty neighbour pixels during the raster scan, and a serve/run/miss state machine.
- Sits between the VGA timing generator (hcount/vcount/pixpulse) and the pixel mux; draw_ball feeds the mux, and bounce/miss pulses feed game logic.

Parameters:
- XSIZE, 5, ball width in pixels; odd, 3..15.
- YSIZE, 5, ball height in pixels; odd, 3..15.
- MAXSTEP, 4, maximum pixels moved per axis per move; 1..7.
- XDIR_START, 0, initial x direction (0=left, 1=right).
- YDIR_START, 0, initial y direction (0=up, 1=down).
- YMISS, 479, vcount row; ball bottom edge reaching it = miss.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous active-high reset
- pixpulse  in  1  pixel-rate enable, one clk in four; all state updates qualified by it
- hcount  in  10  current x being drawn (0=left)
- vcount  in  10  current y being drawn (0=top)
- xloc_start  in  10  serve/reset x-centre
- yloc_start  in  10  serve/reset y-centre
- empty  in  1  current pixel holds no other object
- move  in  1  once-per-frame update strobe
- serve  in  1  launch request from IDLE
- xstep  in  3  x pixels per move; 0 and >MAXSTEP clamp
- ystep  in  3  y pixels per move; same clamping
- draw_ball  out  1  current pixel inside ball
- xloc  out  10  ball x-centre
- yloc  out  10  ball y-centre
- xdir  out  1  current x direction
- ydir  out  1  current y direction
- bounce_x  out  1  one-pixpulse pulse on x reversal
- bounce_y  out  1  one-pixpulse pulse on y reversal
- miss  out  1  one-pixpulse pulse on entering IDLE from RUN
- running  out  1  high in RUN state
- hit_count  out  16  bounce counter (optional feature)

Behaviour:
- Reset, on a clk edge with rst high, regardless of pixpulse: xloc=xloc_start, yloc=yloc_start, xdir=XDIR_START, ydir=YDIR_START; bounce_x, bounce_y and miss = 0; running=0; state=IDLE; rings cleared; hit_count=0. Reset mid-move wins over move.
- HX=(XSIZE-1)/2 and HY=(YSIZE-1)/2. draw_ball is combinational and is active in every state: xloc-HX<=hcount<=xloc+HX and yloc-HY<=vcount<=yloc+HY.
- Neighbour rings: lft/rgt columns (YSIZE+2 bits, index 0 = bottom) and top/bot rows (XSIZE+2 bits, index 0 = rightmost). A bit is set on pixpulse when ~empty and the pixel lies on that ring, at hcount==xloc±(HX+1) or vcount==yloc±(HY+1). All rings clear on the pixpulse following an applied move, so sensing covers exactly one frame.
- Blocked predicates per heading: a side is blocked if any of its ring bits, excluding the far corner, is set. A corner-only hit (diagonal corner bit set, both adjacent sides clear) reverses both axes.
- States:
  - IDLE: position held at xloc_start/yloc_start and tracks those inputs; move ignored. serve on pixpulse -> RUN, direction reloaded from XDIR_START/YDIR_START, rings cleared.
  - RUN: on pixpulse&move, each axis moves s pixels in its direction, or, if blocked, reverses direction and moves s pixels the other way, where s = clamp(step, 1, MAXSTEP). Each reversal pulses bounce_x or bounce_y for one pixpulse period. Simultaneous x and y reversals pulse both.
  - Miss: after a RUN move, yloc+HY>=YMISS -> IDLE, miss pulse, position reloaded on the next pixpulse.
- Edge clamp: arithmetic is 10-bit unsigned. A move that would underflow below HX (x) or HY (y) is instead a reversal with a bounce pulse; the screen edge acts as a wall even if empty is high there.
- serve in RUN is ignored. move and serve together in IDLE: serve wins and no motion occurs that cycle.
- Outputs change only on pixpulse edges, except on reset.

Optional Feature:
- HIT_COUNT_EN defined: hit_count increments by 1 per move with any reversal (x, y, or both count as one). It saturates at 16'hFFFF, clears on rst, and clears on serve.
- HIT_COUNT_EN undefined: hit_count is tied to 0 and no counter logic is built.

Test Plan:
- rst with xloc_start=320, yloc_start=240 -> xloc=320, yloc=240, running=0; 10 move strobes -> no motion.
- serve, then move with xstep=ystep=1, dirs 0/0, all empty -> xloc=319, yloc=239, running=1.
- xstep=0 and xstep=7 with MAXSTEP=4 -> x moves 1 and 4 pixels per move respectively.
- non-empty column at hcount=xloc-3 (XSIZE=5) spanning the ball height -> next move: xdir=1, xloc+1, bounce_x pulse, y unchanged.
- only the top-left corner pixel non-empty while heading up-left -> both dirs flip, both bounce pulses, hit_count+1.
- heading down with yloc=474 (YSIZE=5, YMISS=479), move -> miss pulse, running=0, position back to start; rst asserted during a move -> reset values on that edge.
